uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port among N_REQ requesters on a frame basis.
- Round-robin grant; a frame ends with req_last. Gates bytes with CTS flow control.
- Forfeits the grant from a requester that stalls mid-frame.
- Sits between the protocol/packet sources and the UART TX byte interface (valid/ready).

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, byte width on all data ports
- TIMEOUT_CYCLES, 1024, stall cycles mid-frame before grant is revoked; 0 disables the timeout
- HDR_BASE, 8'hA0, base value of the header byte (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low; reset==0 at a clk edge resets the block
- req_valid  input  N_REQ  per-requester byte valid
- req_data  input  N_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  N_REQ  marks the final byte of the frame
- req_ready  output  N_REQ  per-requester byte accepted
- tx_valid  output  1  byte to UART TX valid
- tx_data  output  DATA_WIDTH  byte to UART TX
- tx_ready  input  1  UART TX accepts byte
- CTS  input  1  clear-to-send from remote; 1 = sending allowed
- grant  output  N_REQ  one-hot current owner; 0 when idle
- busy  output  1  a frame is in progress
- timeout_err  output  1  one-cycle pulse when a grant is revoked
- timeout_id  output  $clog2(N_REQ)  owner that timed out; holds until the next timeout

Behaviour:
- States: IDLE, ARB, (HDR), XFER.
- Reset values: state IDLE; rr_ptr 0; all outputs 0; tx_data 0; timeout counter 0.
- IDLE:
  - If any req_valid is set, go to ARB on the next cycle.
  - Otherwise stay in IDLE.
- ARB (1 cycle):
  - Select the first requester with req_valid set, searching from rr_ptr upward with wrap at N_REQ-1 -> 0.
  - Register that requester's one-hot grant and set busy=1.
  - Go to XFER, or to HDR when the feature is enabled.
  - If no req_valid is set by this cycle, return to IDLE with grant=0.
- XFER, combinational passthrough for the owner g:
  - tx_valid = req_valid[g] & CTS
  - tx_data = req_data[g]
  - req_ready[g] = tx_ready & CTS
  - All other req_ready bits are 0.
- Handshake occurs when tx_valid & tx_ready.
  - On a handshake with req_last[g]=1: next state IDLE, grant=0, busy=0, rr_ptr=(g+1) mod N_REQ.
- Latency: first byte of a frame is offered 2 cycles after req_valid rises in IDLE. Frames are always separated by at least 2 cycles (IDLE, ARB).
- Timeout counter:
  - Cleared on every handshake and on entering XFER.
  - Increments each XFER cycle with no handshake while CTS=1.
  - Frozen while CTS=0, since a remote stall is not the requester's fault.
  - When it reaches TIMEOUT_CYCLES (non-zero): go to IDLE, pulse timeout_err, load timeout_id=g, rr_ptr=(g+1) mod N_REQ.
  - Any remaining bytes of that frame are treated as a new frame at the next grant.
- CTS dropping mid-frame: the byte in flight is not withdrawn by the arbiter. tx_valid falls combinationally and the grant is held.
- Requester deasserting req_valid mid-frame: the grant is held (subject to the timeout).
- Reset asserted mid-frame: immediate return to reset values on that edge. Partial frames are abandoned without error.
- tx_valid never depends on tx_ready.
- At most one grant bit is set at any time.

Optional Feature:
- Macro: UART_ARB_ID_HDR_EN
- Defined:
  - An HDR state follows ARB.
  - tx_valid = CTS, tx_data = HDR_BASE + g (width DATA_WIDTH, wraps modulo 2^DATA_WIDTH), all req_ready = 0.
  - After the header handshake, go to XFER. The timeout counter is cleared on entering XFER.
  - The timeout does not apply in HDR.
- Undefined: the HDR state does not exist; ARB goes directly to XFER.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all req_valid=1 -> grant=0, tx_valid=0, busy=0, req_ready=0 throughout.
- Round-robin:
  - req_valid=4'b1011, each requester sends a 2-byte frame, tx_ready=1, CTS=1.
  - Expect grant order 0001, 0010, 1000, 0001.
  - Expect 2 idle cycles between frames and bytes delivered in order.
- CTS stall:
  - Requester 2 sends frame 11 22 33; drop CTS for 5000 cycles after byte 11.
  - Expect tx_valid=0 during the stall, no timeout_err, grant held.
  - After CTS=1 returns, expect 22 and 33 delivered.
- Timeout:
  - TIMEOUT_CYCLES=16; requester 1 sends one byte without last, then req_valid=0.
  - Expect timeout_err pulse exactly 16 cycles after the last handshake, timeout_id=1, grant to requester 2 if valid.
- Backpressure:
  - Toggle tx_ready with 50% random duty on a 64-byte frame.
  - Expect no lost or duplicated bytes, and req_ready[g] equal to the accepted-byte count.
- With UART_ARB_ID_HDR_EN defined, requester 3 sends frame 5A -> UART TX receives A3 then 5A.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Frame-based round-robin arbiter that shares one UART TX byte port among N_REQ requesters.
// Optional macro UART_ARB_ID_HDR_EN prepends a header byte (HDR_BASE + owner) to every frame.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
`ifdef UART_ARB_ID_HDR_EN
    ,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE = 8'hA0
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    input  logic                          CTS,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [$clog2(N_REQ)-1:0]      timeout_id,
    output logic [1:0]                    dbg_state_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
`ifdef UART_ARB_ID_HDR_EN
        S_HDR  = 2'd2,
`endif
        S_XFER = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  terr_q, terr_d;
    logic [IW-1:0]         tid_q, tid_d;

    logic                  found;
    logic [IW-1:0]         sel;
    logic [IW-1:0]         cand;
    logic [IW-1:0]         nxt_rr;
    logic [DATA_WIDTH-1:0] own_data;

    assign own_data    = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign nxt_rr      = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;
    assign dbg_state_o = state_q;

    // First valid requester at or after rr_q, wrapping at N_REQ-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Byte transfer on either side happens in a cycle where valid and ready are both high;
    // tx_valid is formed from req_valid and CTS only, never from tx_ready.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        tmo_d     = tmo_q;
        terr_d    = 1'b0;
        tid_d     = tid_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                if (found) begin
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    busy_d       = 1'b1;
                    tmo_d        = '0;
`ifdef UART_ARB_ID_HDR_EN
                    state_d      = S_HDR;
`else
                    state_d      = S_XFER;
`endif
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            S_HDR: begin
                tx_valid = CTS;
                tx_data  = HDR_BASE + DATA_WIDTH'(owner_q);
                if (tx_valid && tx_ready) begin
                    state_d = S_XFER;
                    tmo_d   = '0;
                end
            end
`endif
            S_XFER: begin
                tx_valid           = req_valid[owner_q] & CTS;
                tx_data            = own_data;
                req_ready[owner_q] = tx_ready & CTS;
                if (tx_valid && tx_ready) begin
                    tmo_d = '0;
                    if (req_last[owner_q]) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        rr_d    = nxt_rr;
                    end
                end else if (CTS && (TIMEOUT_CYCLES != 0)) begin
                    // The counter only runs while the remote allows sending.
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        rr_d    = nxt_rr;
                        tmo_d   = '0;
                        terr_d  = 1'b1;
                        tid_d   = owner_q;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            terr_q  <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            terr_q  <= terr_d;
            tid_q   <= tid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-fed requesters, a frame-level round-robin
// reference model and a scoreboard of {grant, byte} pairs seen on the TX port.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic tx_valid, tx_ready, cts, busy, timeout_err;
  logic [W-1:0] tx_data;
  logic [1:0] timeout_id, dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] src_d[N][$];
  bit src_l[N][$];
  bit src_en[N];
  bit pop_pend[N];
  logic [W-1:0] mdl_b[N][$];
  int mdl_len[N][$];
  int m_rr = 0;
  int frm_start[$];
  logic [N+W-1:0] exp_q[$];
  logic [N+W-1:0] obs_q[$];
  int obs_cyc[$];
  int rdy_cnt[N];

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .CTS(cts), .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .timeout_id(timeout_id), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- requester driver ----------------
  initial begin
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pop_pend[i]) begin
          void'(src_d[i].pop_front());
          void'(src_l[i].pop_front());
          pop_pend[i] = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = src_en[i] && (src_d[i].size() > 0);
        req_data[i*W +: W] = (src_d[i].size() > 0) ? src_d[i][0] : '0;
        req_last[i] = (src_d[i].size() > 0) ? src_l[i][0] : 1'b0;
      end
    end
  end

  // ---------------- monitor + invariants ----------------
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) pop_pend[i] = 1'b1;
        rdy_cnt[i] += int'(req_ready[i]);
      end
      if (tx_valid && tx_ready) begin
        obs_q.push_back({grant, tx_data});
        obs_cyc.push_back(cyc);
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL onehot_grant cyc %0d got %b", cyc, grant);
      end
      checks++;
      if (!cts && tx_valid) begin
        errors++;
        $display("FAIL cts_gate cyc %0d tx_valid got 1 exp 0", cyc);
      end
      checks++;
      if ((req_ready & ~grant) !== '0) begin
        errors++;
        $display("FAIL ready_owner cyc %0d req_ready %b grant %b", cyc, req_ready, grant);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_frame(input int r, input int len, input logic [W-1:0] b0,
                           input logic [W-1:0] step, input bit rnd, input bit last);
    logic [W-1:0] b, d;
    b = b0;
    for (int k = 0; k < len; k++) begin
      d = rnd ? W'($urandom) : b;
      src_d[r].push_back(d);
      src_l[r].push_back(last && (k == len - 1));
      mdl_b[r].push_back(d);
      b = b + step;
    end
    mdl_len[r].push_back(len);
    src_en[r] = 1'b1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_d[i].delete();
      src_l[i].delete();
      mdl_b[i].delete();
      mdl_len[i].delete();
      pop_pend[i] = 1'b0;
      rdy_cnt[i] = 0;
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Frame-level reference: among requesters with queued frames, serve the first at or after
  // the pointer, send its whole frame (with header when enabled), then move past it.
  task automatic model_build();
    int g, c, len;
    logic [N-1:0] oh;
    exp_q.delete();
    frm_start.delete();
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && mdl_len[c].size() > 0) g = c;
      end
      if (g < 0) break;
      oh = '0;
      oh[g] = 1'b1;
      frm_start.push_back(exp_q.size());
`ifdef UART_ARB_ID_HDR_EN
      exp_q.push_back({oh, W'(8'hA0 + g)});
`endif
      len = mdl_len[g].pop_front();
      for (int k = 0; k < len; k++) exp_q.push_back({oh, mdl_b[g].pop_front()});
      m_rr = (g + 1) % N;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) add_frame(i, 1, W'(8'h10 * i), 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (grant !== '0) begin errors++; $display("FAIL rst_grant got %b exp 0", grant); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
      checks++;
      if (timeout_err !== 1'b0 || timeout_id !== '0 || tx_data !== '0) begin
        errors++;
        $display("FAIL rst_misc got err %b id %0d data %h exp 0", timeout_err, timeout_id, tx_data);
      end
    end
    @(posedge clk);
    #1;
    clear_all();
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_rst got busy %b grant %b state %0d exp 0", busy, grant, dbg_state);
    end
    tick(1);
  endtask

  task automatic test_round_robin();
    int load_cyc, s, d;
    clear_all();
    add_frame(0, 2, 8'h01, 8'h01, 1'b0, 1'b1);
    add_frame(0, 2, 8'h05, 8'h01, 1'b0, 1'b1);
    add_frame(1, 2, 8'h11, 8'h01, 1'b0, 1'b1);
    add_frame(3, 2, 8'h31, 8'h01, 1'b0, 1'b1);
    load_cyc = cyc;
    model_build();
    for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) tick(1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rr_byte[%0d] got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_cyc[0] != load_cyc + 2) begin
        errors++;
        $display("FAIL rr_latency got %0d exp %0d", obs_cyc[0] - load_cyc, 2);
      end
    end
    for (int k = 1; k < obs_q.size(); k++) begin
      s = 0;
      foreach (frm_start[f]) if (frm_start[f] == k) s = 1;
      d = obs_cyc[k] - obs_cyc[k-1];
      checks++;
      if (d != (s ? 3 : 1)) begin
        errors++;
        $display("FAIL rr_spacing[%0d] got %0d exp %0d", k, d, s ? 3 : 1);
      end
    end
    tick(3);
  endtask

  task automatic test_cts_stall();
    int idx, bad_v, bad_g, bad_t, bad_b, n_before;
    clear_all();
    add_frame(2, 3, 8'h11, 8'h11, 1'b0, 1'b1);
    model_build();
    idx = -1;
    for (int t = 0; t < 50 && idx < 0; t++) begin
      tick(1);
      foreach (obs_q[k]) if (obs_q[k][W-1:0] == 8'h11) idx = k;
    end
    checks++;
    if (idx < 0) begin errors++; $display("FAIL cts_first_byte got none exp 11"); end
    cts = 1'b0;
    bad_v = 0; bad_g = 0; bad_t = 0; bad_b = 0;
    n_before = obs_q.size();
    repeat (5000) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) bad_v++;
      if (grant !== 4'b0100) bad_g++;
      if (timeout_err !== 1'b0) bad_t++;
      if (busy !== 1'b1) bad_b++;
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL cts_tx_valid cycles_high got %0d exp 0", bad_v); end
    checks++;
    if (bad_g != 0) begin errors++; $display("FAIL cts_grant cycles_wrong got %0d exp 0", bad_g); end
    checks++;
    if (bad_t != 0) begin errors++; $display("FAIL cts_timeout pulses got %0d exp 0", bad_t); end
    checks++;
    if (bad_b != 0 || obs_q.size() != n_before) begin
      errors++;
      $display("FAIL cts_hold busy_low %0d bytes %0d exp 0 %0d", bad_b, obs_q.size(), n_before);
    end
    @(posedge clk);
    #1;
    cts = 1'b1;
    for (int t = 0; t < 50 && obs_q.size() < exp_q.size(); t++) tick(1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cts_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL cts_byte[%0d] got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    tick(3);
  endtask

  task automatic test_timeout();
    int idx, h, t_err, g1, g2, c, got55;
    logic [N-1:0] oh1, oh2;
    clear_all();
    g1 = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (g1 < 0 && (c == 1 || c == 2)) g1 = c;
    end
    g2 = (g1 == 1) ? 2 : 1;
    oh1 = '0; oh1[g1] = 1'b1;
    oh2 = '0; oh2[g2] = 1'b1;
    add_frame(1, 1, 8'h44, 8'h00, 1'b0, 1'b0);
    add_frame(2, 1, 8'h55, 8'h00, 1'b0, 1'b1);
    idx = -1;
    for (int t = 0; t < 50 && idx < 0; t++) begin
      tick(1);
      foreach (obs_q[k]) if (obs_q[k][W-1:0] == 8'h44) idx = k;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL tmo_byte got none exp 44");
    end else begin
      checks++;
      if (obs_q[idx][N+W-1:W] !== oh1) begin
        errors++;
        $display("FAIL tmo_first_grant got %b exp %b", obs_q[idx][N+W-1:W], oh1);
      end
      h = obs_cyc[idx];
      t_err = -1;
      for (int t = 0; t < 100 && t_err < 0; t++) begin
        @(negedge clk);
        if (timeout_err === 1'b1) t_err = cyc;
      end
      // Handshake edge to revoke edge spans TMO stalled cycles; the pulse follows the revoke edge.
      checks++;
      if (t_err != h + TMO + 1) begin
        errors++;
        $display("FAIL tmo_pulse_time got %0d exp %0d", t_err - h, TMO + 1);
      end
      checks++;
      if (timeout_id !== 2'(g1)) begin
        errors++;
        $display("FAIL tmo_id got %0d exp %0d", timeout_id, g1);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_pulse_width got %b exp 0", timeout_err);
      end
      @(negedge clk);
      checks++;
      if (grant !== oh2) begin
        errors++;
        $display("FAIL tmo_next_grant got %b exp %b", grant, oh2);
      end
    end
    got55 = 0;
    for (int t = 0; t < 50 && got55 == 0; t++) begin
      tick(1);
      foreach (obs_q[k]) if (obs_q[k] == {oh2, 8'h55}) got55 = 1;
    end
    checks++;
    if (got55 == 0 || timeout_id !== 2'(g1)) begin
      errors++;
      $display("FAIL tmo_after got55 %0d id %0d exp 1 %0d", got55, timeout_id, g1);
    end
    m_rr = (g2 + 1) % N;
    tick(3);
  endtask

  task automatic test_backpressure();
    int g, low_run;
    clear_all();
    g = $urandom_range(0, N - 1);
    add_frame(g, 64, 8'h00, 8'h00, 1'b1, 1'b1);
    model_build();
    low_run = 0;
    for (int t = 0; t < 2000 && obs_q.size() < exp_q.size(); t++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (!tx_ready) low_run++;
      if (low_run > 4) begin
        tx_ready = 1'b1;
        low_run = 0;
      end
      if (tx_ready) low_run = 0;
      tick(1);
    end
    tx_ready = 1'b1;
    tick(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL bp_byte[%0d] got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (rdy_cnt[g] != 64) begin
      errors++;
      $display("FAIL bp_ready_count got %0d exp 64", rdy_cnt[g]);
    end
    tick(3);
  endtask

  task automatic test_random();
    int streak, nf;
    bit c, r;
    clear_all();
    for (int i = 0; i < N; i++) begin
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) add_frame(i, $urandom_range(1, 6), 8'h00, 8'h00, 1'b1, 1'b1);
    end
    model_build();
    streak = 0;
    for (int t = 0; t < 3000 && obs_q.size() < exp_q.size(); t++) begin
      c = ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      if (c && !r) streak++;
      else if (c && r) streak = 0;
      if (streak >= 6) begin
        c = 1'b1;
        r = 1'b1;
        streak = 0;
      end
      cts = c;
      tx_ready = r;
      tick(1);
    end
    cts = 1'b1;
    tx_ready = 1'b1;
    tick(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rnd_byte[%0d] got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    tick(3);
  endtask

`ifdef UART_ARB_ID_HDR_EN
  task automatic test_hdr();
    clear_all();
    add_frame(3, 1, 8'h5A, 8'h00, 1'b0, 1'b1);
    model_build();
    for (int t = 0; t < 50 && obs_q.size() < 2; t++) tick(1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL hdr_count got %0d exp 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0][W-1:0] !== 8'hA3 || obs_q[1][W-1:0] !== 8'h5A) begin
        errors++;
        $display("FAIL hdr_bytes got %h %h exp a3 5a", obs_q[0][W-1:0], obs_q[1][W-1:0]);
      end
    end
    tick(3);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b0;
    cts = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_en[i] = 1'b0;
      pop_pend[i] = 1'b0;
      rdy_cnt[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_cts_stall();
    test_timeout();
    test_backpressure();
    test_random();
`ifdef UART_ARB_ID_HDR_EN
    test_hdr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
